pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 113 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for an in-order pipeline: tracks in-flight writers, raises
// freeze on RAW / load-use hazards, picks forwarding sources, and counts stalls.
module pipe_hazard_ctrl #(
  parameter int NSTAGE = 3,
  parameter int RA_W   = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                mode,
  input  logic                      id_valid,
  input  logic [RA_W-1:0]           id_src1,
  input  logic [RA_W-1:0]           id_src2,
  input  logic                      id_two_src,
  input  logic [RA_W-1:0]           id_dest,
  input  logic                      id_wb_en,
  input  logic                      id_mem_r_en,
  input  logic                      branch_taken,
  input  logic                      stat_clr,
  output logic                      freeze,
  output logic                      flush,
  output logic [$clog2(NSTAGE)-1:0] sel_src1,
  output logic [$clog2(NSTAGE)-1:0] sel_src2,
  output logic [CNT_W-1:0]          stall_count
);

  localparam int SW = $clog2(NSTAGE);

  typedef struct packed {
    logic            valid;
    logic            wb_en;
    logic            mem_r_en;
    logic [RA_W-1:0] dest;
    logic [RA_W-1:0] src1;
    logic [RA_W-1:0] src2;
    logic            two_src;
  } slot_t;

  slot_t            slot_q [NSTAGE];
  slot_t            slot0_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             raw_hazard, load_use, freeze_pre;

  function automatic logic producer(input slot_t s, input logic [RA_W-1:0] r);
    return s.valid & s.wb_en & (s.dest == r);
  endfunction

  function automatic logic id_hit(input slot_t s, input logic v, input logic two,
                                  input logic [RA_W-1:0] r1, input logic [RA_W-1:0] r2);
    return v & (producer(s, r1) | (two & producer(s, r2)));
  endfunction

  // The last slot is skipped: the register file writes it before ID reads.
  always_comb begin
    raw_hazard = 1'b0;
    for (int k = 0; k < NSTAGE - 1; k++) begin
      if (id_hit(slot_q[k], id_valid, id_two_src, id_src1, id_src2)) raw_hazard = 1'b1;
    end
    load_use = id_hit(slot_q[0], id_valid, id_two_src, id_src1, id_src2) & slot_q[0].mem_r_en;
    case (mode)
      2'd0:    freeze_pre = raw_hazard;
      2'd1:    freeze_pre = 1'b0;
      default: freeze_pre = load_use;
    endcase
    freeze = rst & ~branch_taken & freeze_pre;
    flush  = rst & branch_taken;
  end

  // Descending scan so the nearest (smallest k) producer wins.
  always_comb begin
    sel_src1 = '0;
    sel_src2 = '0;
    for (int k = NSTAGE - 1; k >= 1; k--) begin
      if (producer(slot_q[k], slot_q[0].src1)) sel_src1 = SW'(k);
      if (producer(slot_q[k], slot_q[0].src2)) sel_src2 = SW'(k);
    end
    if (!rst || mode == 2'd0 || !slot_q[0].valid) begin
      sel_src1 = '0;
      sel_src2 = '0;
    end
    if (!slot_q[0].two_src) sel_src2 = '0;
  end

  always_comb begin
    slot0_d = '0;
    if (!freeze && !flush) begin
      slot0_d.valid    = id_valid;
      slot0_d.wb_en    = id_wb_en;
      slot0_d.mem_r_en = id_mem_r_en;
      slot0_d.dest     = id_dest;
      slot0_d.src1     = id_src1;
      slot0_d.src2     = id_src2;
      slot0_d.two_src  = id_two_src;
    end
    cnt_d = cnt_q;
    if (stat_clr)                   cnt_d = '0;
    else if (freeze && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NSTAGE; k++) slot_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      slot_q[0] <= slot0_d;
      for (int k = 1; k < NSTAGE; k++) slot_q[k] <= slot_q[k-1];
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic, checked
// against an instruction-history model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int NSTAGE = 3;
  localparam int RA_W   = 4;
  localparam int CNT_W  = 4;
  localparam int SW     = $clog2(NSTAGE);

  logic            clk;
  logic            rst;
  logic [1:0]      mode;
  logic            id_valid, id_two_src, id_wb_en, id_mem_r_en;
  logic [RA_W-1:0] id_src1, id_src2, id_dest;
  logic            branch_taken, stat_clr;
  logic            freeze, flush;
  logic [SW-1:0]   sel_src1, sel_src2;
  logic [CNT_W-1:0] stall_count;

  int errors = 0;
  int checks = 0;

  pipe_hazard_ctrl #(.NSTAGE(NSTAGE), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .branch_taken(branch_taken), .stat_clr(stat_clr),
    .freeze(freeze), .flush(flush), .sel_src1(sel_src1), .sel_src2(sel_src2),
    .stall_count(stall_count)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction history: hist[0] is the instruction now in EXE, hist[i] is i stages later.
  typedef struct {
    bit       valid;
    bit       wb;
    bit       ld;
    int       dest;
    int       s1;
    int       s2;
    bit       two;
  } instr_t;

  instr_t hist[$];
  int     exp_cnt;
  bit     e_freeze, e_flush;
  int     e_sel1, e_sel2;

  function automatic bit writes(instr_t i, int r);
    return i.valid && i.wb && i.dest == r;
  endfunction

  function automatic bit id_reads_result_of(instr_t i);
    if (!id_valid) return 0;
    return writes(i, int'(id_src1)) || (id_two_src && writes(i, int'(id_src2)));
  endfunction

  function automatic int nearest_writer(int r);
    for (int age = 1; age < NSTAGE; age++) if (writes(hist[age], r)) return age;
    return 0;
  endfunction

  task automatic model_reset();
    instr_t b;
    b = '{default: 0};
    hist.delete();
    for (int i = 0; i < NSTAGE; i++) hist.push_back(b);
    exp_cnt = 0;
  endtask

  task automatic compute_exp();
    bit raw, lu, f;
    raw = 0;
    for (int age = 0; age < NSTAGE - 1; age++) if (id_reads_result_of(hist[age])) raw = 1;
    lu = id_reads_result_of(hist[0]) && hist[0].ld;
    f = (mode == 0) ? raw : (mode == 1) ? 1'b0 : lu;
    e_freeze = rst && !branch_taken && f;
    e_flush  = rst && branch_taken;
    e_sel1 = 0;
    e_sel2 = 0;
    if (rst && mode != 0 && hist[0].valid) begin
      e_sel1 = nearest_writer(hist[0].s1);
      if (hist[0].two) e_sel2 = nearest_writer(hist[0].s2);
    end
  endtask

  task automatic model_edge();
    instr_t n;
    if (!rst) begin
      model_reset();
      return;
    end
    n = '{default: 0};
    if (!e_freeze && !e_flush)
      n = '{valid: id_valid, wb: id_wb_en, ld: id_mem_r_en, dest: int'(id_dest),
            s1: int'(id_src1), s2: int'(id_src2), two: id_two_src};
    hist.push_front(n);
    void'(hist.pop_back());
    if (stat_clr)                        exp_cnt = 0;
    else if (e_freeze && exp_cnt < 15)   exp_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    compute_exp();
    chk({tag, ".freeze"}, 32'(freeze), 32'(e_freeze));
    chk({tag, ".flush"},  32'(flush),  32'(e_flush));
    chk({tag, ".sel1"},   32'(sel_src1), e_sel1);
    chk({tag, ".sel2"},   32'(sel_src2), e_sel2);
    chk({tag, ".cnt"},    32'(stall_count), exp_cnt);
  endtask

  // driver tasks: inputs change at posedge+1, outputs checked at posedge+4
  task automatic do_cycle(input string tag);
    #3;
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_id(input bit v, input int s1, input int s2, input bit two,
                        input int d, input bit wb, input bit ld);
    id_valid = v; id_src1 = RA_W'(s1); id_src2 = RA_W'(s2); id_two_src = two;
    id_dest = RA_W'(d); id_wb_en = wb; id_mem_r_en = ld;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0);
    branch_taken = 0;
    stat_clr = 1;
    do_cycle("drain");
    stat_clr = 0;
    for (int i = 0; i < NSTAGE; i++) do_cycle("drain");
  endtask

  initial begin
    rst = 0; mode = 0; branch_taken = 1; stat_clr = 0;
    set_id(1, 3, 3, 1, 3, 1, 1);
    model_reset();
    #1;
    do_cycle("reset");
    do_cycle("reset");
    rst = 1; branch_taken = 0;
    drain();

    // stall-only: ADD r3 then reader of r3
    mode = 0;
    set_id(1, 1, 2, 0, 3, 1, 0);
    do_cycle("stall.add");
    set_id(1, 3, 0, 0, 6, 1, 0);
    do_cycle("stall.r1");
    do_cycle("stall.r2");
    do_cycle("stall.go");
    chk("stall.count2", 32'(stall_count), 2);
    drain();

    // forwarding: ADD r3, SUB r3,r3, reuse r3
    mode = 1;
    set_id(1, 1, 2, 0, 3, 1, 0);
    do_cycle("fwd.add");
    set_id(1, 3, 3, 1, 4, 1, 0);
    do_cycle("fwd.sub");
    set_id(1, 3, 3, 1, 5, 1, 0);
    #3;
    chk("fwd.sel1_is1", 32'(sel_src1), 1);
    chk("fwd.sel2_is1", 32'(sel_src2), 1);
    #(-3 + 3);
    do_cycle("fwd.reuse");
    #3;
    chk("fwd.reuse_sel1_is2", 32'(sel_src1), 2);
    #(0);
    set_id(0, 0, 0, 0, 0, 0, 0);
    do_cycle("fwd.tail");
    drain();

    // load-use: LDR r5, consumer reads src2 = 5
    mode = 2;
    set_id(1, 1, 2, 0, 5, 1, 1);
    do_cycle("lu.ldr");
    set_id(1, 0, 5, 1, 7, 1, 0);
    #3;
    chk("lu.freeze_on", 32'(freeze), 1);
    #(0);
    do_cycle("lu.stall");
    do_cycle("lu.go");
    set_id(0, 0, 0, 0, 0, 0, 0);
    #3;
    chk("lu.sel2_is2", 32'(sel_src2), 2);
    chk("lu.count1", 32'(stall_count), 1);
    do_cycle("lu.tail");
    drain();

    // branch overrides hazard
    mode = 0;
    set_id(1, 1, 2, 0, 3, 1, 0);
    do_cycle("br.add");
    set_id(1, 3, 0, 0, 6, 1, 0);
    branch_taken = 1;
    #3;
    chk("br.freeze0", 32'(freeze), 0);
    chk("br.flush1",  32'(flush), 1);
    do_cycle("br.cycle");
    branch_taken = 0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    do_cycle("br.after");
    drain();

    // saturation then clear while freezing
    mode = 0;
    for (int it = 0; it < 10; it++) begin
      set_id(1, 1, 2, 0, 7, 1, 0);
      do_cycle("sat.add");
      set_id(1, 7, 0, 0, 8, 1, 0);
      do_cycle("sat.r1");
      do_cycle("sat.r2");
    end
    #3;
    chk("sat.count15", 32'(stall_count), 15);
    set_id(1, 1, 2, 0, 7, 1, 0);
    do_cycle("clr.add");
    set_id(1, 7, 0, 0, 8, 1, 0);
    stat_clr = 1;
    do_cycle("clr.freeze");
    stat_clr = 0;
    #3;
    chk("clr.count0", 32'(stall_count), 0);
    do_cycle("clr.after");
    drain();

    // async reset with three valid slots in flight
    mode = 0;
    set_id(1, 1, 2, 0, 3, 1, 0); do_cycle("ar.i0");
    set_id(1, 1, 2, 0, 4, 1, 0); do_cycle("ar.i1");
    set_id(1, 1, 2, 0, 5, 1, 0); do_cycle("ar.i2");
    set_id(1, 4, 3, 1, 9, 1, 0);
    do_cycle("ar.hazard");
    branch_taken = 1;
    #1;
    rst = 0;
    model_reset();
    #1;
    chk("ar.freeze0", 32'(freeze), 0);
    chk("ar.flush0",  32'(flush), 0);
    chk("ar.sel1_0",  32'(sel_src1), 0);
    chk("ar.sel2_0",  32'(sel_src2), 0);
    chk("ar.cnt0",    32'(stall_count), 0);
    #1;
    do_cycle("ar.held");
    rst = 1; branch_taken = 0;
    set_id(1, 4, 3, 1, 9, 1, 0);
    #3;
    chk("ar.release_freeze0", 32'(freeze), 0);
    #(0);
    do_cycle("ar.release");
    drain();

    // random traffic over a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      mode = 2'($urandom_range(0, 3));
      set_id($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      stat_clr = ($urandom_range(0, 39) == 0);
      do_cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
